instr_fetch: RTL
================

Name: instr_fetch

Overview:
Upstream fetch stage for the nano-cpu core. Replaces the core's direct indexing of a 1 KiB instruction array with a real memory port. Reads a byte-wide synchronous instruction memory over 4 cycles, assembles a little-endian 32-bit RV32 instruction, and presents it to proc with a valid/ready handshake. Accepts redirects (taken branches) from proc and reports misaligned or out-of-range fetches.

Parameters:
ADDR_W, 10, byte-address width of instruction memory (1024 bytes)
RESET_PC, 32'h0, first fetch address after reset (must be 4-byte aligned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
mem_rd_en  output  1  byte read strobe to instruction memory
mem_addr  output  ADDR_W  byte address; read data returns exactly 1 cycle after strobe
mem_rdata  input  8  read data for the strobe issued in the previous cycle
instr_valid  output  1  instr_out/instr_pc hold a complete instruction
instr_ready  input  1  proc accepts the instruction (handshake when valid && ready)
instr_out  output  32  assembled instruction, {byte[pc+3], byte[pc+2], byte[pc+1], byte[pc]}
instr_pc  output  32  address of instr_out
redirect_valid  input  1  proc requests a fetch restart (taken branch)
redirect_pc  input  32  restart address
fetch_fault  output  1  sticky fault: misaligned or out-of-range fetch address

Behaviour:
- Reset (rst=0, async): state=FETCH, pc=RESET_PC, issue_cnt=0, recv_cnt=0. All outputs 0: instr_valid, mem_rd_en, mem_addr, instr_out, instr_pc, fetch_fault.
- FETCH state:
  - Cycles 0..3 issue mem_rd_en=1 with mem_addr=pc[ADDR_W-1:0]+issue_cnt.
  - recv_cnt counts returning bytes. Byte k is written to instr_out[8k+7:8k].
  - When byte 3 is captured (cycle 4), go to HOLD: instr_valid=1, instr_pc=pc.
  - Latency: first strobe to instr_valid high is 5 cycles. Back-to-back throughput is 1 instruction per 6 cycles when ready is held high.
- HOLD state:
  - instr_out, instr_pc and instr_valid are stable until the handshake.
  - On valid && ready: instr_valid drops next cycle, pc updates to pc+4, state returns to FETCH.
- Redirect (any state except FAULT) has priority over sequential next_pc:
  - pc <= redirect_pc; counters cleared; in-flight byte returning next cycle is discarded.
  - instr_valid drops; FETCH restarts at redirect_pc the following cycle.
  - If a handshake happens in the same cycle as the redirect, the instruction counts as accepted and the next fetch is from redirect_pc.
- Address check, applied to every new pc (reset, sequential, redirect) before its first strobe. Violations:
  - pc[1:0] != 0, or
  - pc[31:ADDR_W] != 0.
  - On violation: enter FAULT. fetch_fault=1, mem_rd_en=0, instr_valid=0.
  - FAULT is terminal until reset; redirects are ignored.
- Wrap-around: pc+4 that crosses 2^ADDR_W is an out-of-range fault, not a wrap.
- mem_rd_en is never asserted outside FETCH issue cycles.
- Reset mid-fetch: all state is discarded immediately; late mem_rdata is ignored.

Decomposition:
- Shared defs.v gets:
  - FETCH/HOLD/FAULT state encodings (2-bit)
  - RV32_ILEN_BYTES=4
- One natural sub-module: instr_byte_assembler. It holds the 4x8 shift/insert register and recv_cnt, and produces a done pulse and the 32-bit word. It has its own clk/rst (same polarity) and a clear input driven by redirect.

Test Plan:
- Reset with RESET_PC=0, memory bytes 0..3 = 93 00 50 00 -> instr_valid rises 5 cycles after first strobe; instr_out=32'h00500093, instr_pc=0.
- Hold instr_ready=0 for 10 cycles -> instr_out/instr_pc stable, no mem_rd_en; then ready=1 -> next fetch at pc=4, mem_addr sequence 4,5,6,7.
- Assert redirect_valid with redirect_pc=32'h40 at the 2nd strobe of a fetch -> the late byte is dropped; the next instr_valid shows instr_pc=32'h40 and the bytes from 0x40..0x43.
- Assert a handshake and a redirect to 32'h10 in the same HOLD cycle -> exactly one acceptance; next instr_pc=32'h10.
- Redirect to 32'h22 -> fetch_fault=1 next cycle, mem_rd_en stays 0; a further redirect to 32'h0 is ignored until rst pulses low.
- Sequential fetch at pc=32'h3FC accepted -> next pc=32'h400 is out of range -> fetch_fault=1, no strobe issued.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the nano-cpu fetch stage: fetch FSM state encodings,
//   instruction length, counter widths and the fetch-address legality check.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   // RV32 instructions are fetched as four little-endian bytes.
   localparam int RV32_ILEN_BYTES = 4;

   // Index of a byte lane inside one instruction (0..3).
   localparam int BYTE_IDX_W = $clog2(RV32_ILEN_BYTES);

   // Strobe counter must also represent "all bytes issued" (0..4).
   localparam int ISSUE_W = $clog2(RV32_ILEN_BYTES + 1);

   typedef enum logic [1:0] {
      FETCH = 2'd0,  // issuing byte reads / collecting returned bytes
      HOLD  = 2'd1,  // complete instruction presented, waiting for proc
      FAULT = 2'd2   // illegal fetch address seen; terminal until reset
   } fetch_state_t;

   // A fetch address is legal when it is instruction aligned and lies
   // entirely inside the 2**addr_w byte instruction memory.
   function automatic logic pc_legal(input logic [31:0] pc,
                                     input int unsigned addr_w);
      logic [31:0] hi_mask;
      hi_mask = 32'hFFFF_FFFF << addr_w;
      return (pc[1:0] == 2'b00) && ((pc & hi_mask) == 32'h0);
   endfunction

endpackage

// File: rtl/instr_byte_assembler.sv
// -----------------------------------------------------------------------------
// instr_byte_assembler
//   Collects the bytes of one instruction as they return from memory and
//   inserts byte k into lane k of a 32-bit word.
//
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   clear      : abandon the partially assembled word (fetch redirect)
//   byte_valid : byte_in carries the next returned byte this cycle
//   byte_in    : returned byte
//   done       : this cycle's byte completes the word (combinational pulse)
//   word       : assembled word including this cycle's byte; valid with done
// -----------------------------------------------------------------------------
module instr_byte_assembler
   import instr_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        done,
   output logic [31:0] word
);

   logic [RV32_ILEN_BYTES-1:0][7:0] lanes;
   logic [RV32_ILEN_BYTES-1:0][7:0] word_lanes;
   logic [BYTE_IDX_W-1:0]           recv_cnt;

   // recv_cnt wraps 3 -> 0 on the final byte, so the next fetch starts clean.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the lane register is reset as well, so the assembled word is
         // never X even if a partially filled lane were ever exposed.
         lanes    <= '0;
         recv_cnt <= '0;
      end else if (clear) begin
         recv_cnt <= '0;
      end else if (byte_valid) begin
         // NOTE: non-blocking assignments keep every register in this block
         // reading its pre-edge value, independent of statement order.
         lanes[recv_cnt] <= byte_in;
         recv_cnt        <= recv_cnt + 1'b1;
      end
   end

   // The final byte is merged combinationally so the top can register the
   // complete word on the same edge that captures byte 3.
   always_comb begin
      // NOTE: full default before the conditional update, so no latch.
      word_lanes           = lanes;
      word_lanes[recv_cnt] = byte_in;
   end

   assign word = word_lanes;
   assign done = byte_valid && !clear &&
                 (recv_cnt == BYTE_IDX_W'(RV32_ILEN_BYTES - 1));

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage for the nano-cpu core. Reads four bytes from a byte-wide
//   synchronous instruction memory (1-cycle read latency), assembles a
//   little-endian RV32 instruction and hands it to proc over valid/ready.
//   Taken-branch redirects restart the fetch; misaligned or out-of-range
//   fetch addresses park the stage in a sticky FAULT state until reset.
//
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   mem_rd_en      : byte read strobe to instruction memory
//   mem_addr       : byte address for the strobe
//   mem_rdata      : data for the strobe issued in the previous cycle
//   instr_valid    : instr_out / instr_pc hold a complete instruction
//   instr_ready    : proc accepts the instruction (valid && ready)
//   instr_out      : {byte[pc+3], byte[pc+2], byte[pc+1], byte[pc]}
//   instr_pc       : address of instr_out
//   redirect_valid : proc requests a fetch restart
//   redirect_pc    : restart address
//   fetch_fault    : sticky misaligned / out-of-range fetch indication
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_out,
   output logic [31:0]       instr_pc,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              fetch_fault
);

   fetch_state_t       state;
   logic [31:0]        pc;
   logic [ISSUE_W-1:0] issue_cnt;
   logic               rd_pend;      // a strobe was issued last cycle

   logic               redirect_take;
   logic               handshake;
   logic               start_fetch;
   logic [31:0]        start_pc;
   logic               asm_done;
   logic [31:0]        asm_word;

   assign redirect_take = redirect_valid && (state != FAULT);
   assign handshake     = instr_valid && instr_ready;

   // Every new pc (redirect, sequential after a handshake, or the reset pc
   // on the first cycle out of reset) goes through the same start path, where
   // it is checked and, if legal, its first strobe is issued immediately.
   always_comb begin
      start_fetch = 1'b0;
      start_pc    = pc;
      if (redirect_take) begin
         start_fetch = 1'b1;
         start_pc    = redirect_pc;
      end else if ((state == HOLD) && handshake) begin
         start_fetch = 1'b1;
         start_pc    = pc + 32'd4;
      end else if ((state == FETCH) && (issue_cnt == '0)) begin
         // Only reachable directly after reset: every other start leaves
         // issue_cnt at 1.
         start_fetch = 1'b1;
      end
   end

   // The byte returning in the cycle after a redirect belongs to the old
   // fetch; rd_pend is cleared on redirect so it is never presented.
   instr_byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (redirect_take),
      .byte_valid (rd_pend && (state == FETCH)),
      .byte_in    (mem_rdata),
      .done       (asm_done),
      .word       (asm_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         issue_cnt   <= '0;
         rd_pend     <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         instr_valid <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
         fetch_fault <= 1'b0;
      end else begin
         rd_pend <= mem_rd_en && !redirect_take;

         if (state == FAULT) begin
            // Terminal: no strobes, no instructions, redirects ignored.
            mem_rd_en   <= 1'b0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b1;
            rd_pend     <= 1'b0;
         end else if (start_fetch) begin
            pc          <= start_pc;
            instr_valid <= 1'b0;
            if (!pc_legal(start_pc, ADDR_W)) begin
               state       <= FAULT;
               fetch_fault <= 1'b1;
               mem_rd_en   <= 1'b0;
               issue_cnt   <= '0;
               rd_pend     <= 1'b0;
            end else begin
               state     <= FETCH;
               mem_rd_en <= 1'b1;
               mem_addr  <= start_pc[ADDR_W-1:0];
               issue_cnt <= ISSUE_W'(1);
            end
         end else if (state == FETCH) begin
            if (issue_cnt < ISSUE_W'(RV32_ILEN_BYTES)) begin
               mem_rd_en <= 1'b1;
               mem_addr  <= pc[ADDR_W-1:0] + ADDR_W'(issue_cnt);
               issue_cnt <= issue_cnt + 1'b1;
            end else begin
               mem_rd_en <= 1'b0;
            end
            if (asm_done) begin
               state       <= HOLD;
               instr_valid <= 1'b1;
               instr_out   <= asm_word;
               instr_pc    <= pc;
            end
         end
         // HOLD without handshake or redirect: everything holds.
      end
   end

endmodule
